// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, op codes and divider state type
package alu_pkg;

    // Default datapath width for the ALU and its multi-cycle units
    localparam int WIDTH = 32;

    // ALU operation select codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_MUL  = 2'b01;
    localparam logic [1:0] ALU_DIV  = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Quotient reported when the divisor is zero
    localparam logic [WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/full_adder_32.sv
// rtl/full_adder_32.sv - ripple-carry adder with carry in and carry out
module full_adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    // One full-adder cell per bit, carry rippling from LSB to MSB
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/divider_32.sv
// rtl/divider_32.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle
module divider_32
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             r,
    input  logic             load,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             finished,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_q;
    logic [WIDTH-1:0] qreg_q;
    logic [WIDTH-1:0] dreg_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    count_q;
    logic             finished_q;
    logic             dbz_q;

    // Iteration datapath: shift the next dividend bit into the partial remainder
    logic             shift_c;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic             ok;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] qreg_d;

    assign shift_c = rem_q[WIDTH-1];
    assign rs      = {rem_q[WIDTH-2:0], qreg_q[WIDTH-1]};

    // Trial subtraction rs - dreg done as rs + ~dreg + 1; carry out means no borrow
    full_adder_32 #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a_i    (rs),
        .b_i    (~dreg_q),
        .cin_i  (1'b1),
        .sum_o  (trial),
        .cout_o (no_borrow)
    );

    // A bit shifted out of the remainder means rs exceeds any WIDTH-bit divisor
    assign ok     = no_borrow | shift_c;
    assign rem_d  = ok ? trial : rs;
    assign qreg_d = {qreg_q[WIDTH-2:0], ok};

    // Sequencer: reset beats load, load restarts from any state, RUN iterates WIDTH times
    always_ff @(posedge clk) begin
        if (r) begin
            state_q    <= IDLE;
            qreg_q     <= '0;
            dreg_q     <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            finished_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else if (load) begin
            dreg_q     <= y;
            count_q    <= '0;
            finished_q <= 1'b0;
            if (y == '0) begin
                state_q <= DONE;
                qreg_q  <= DIV_BY_ZERO_Q;
                rem_q   <= x;
                dbz_q   <= 1'b1;
            end else begin
                state_q <= RUN;
                qreg_q  <= x;
                rem_q   <= '0;
                dbz_q   <= 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    rem_q   <= rem_d;
                    qreg_q  <= qreg_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    finished_q <= 1'b1;
                end
                default: begin
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    assign q           = qreg_q;
    assign rem         = rem_q;
    assign finished    = finished_q;
    assign div_by_zero = dbz_q;

endmodule
